// File: rtl/ifetch_pkg.sv
// Shared constants and the fetch-buffer entry record for the instruction fetch unit.
package ifetch_pkg;

    localparam int XLEN = 32;

    // Canonical NOP (addi x0, x0, 0). It stands in for the instruction word of a
    // misaligned fetch.
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // Sequential fetch stride in bytes.
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// fetch_fifo: two-entry shift-style buffer between fetch and decode.
// Slot 0 is always the head. The output is read straight from slot 0 without
// regard to the count, so the head outputs stay at zero until the first push
// after reset.
module fetch_fifo
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop;

    // A pop is only meaningful when the buffer holds something.
    assign do_pop = pop && (cnt_q != 2'd0);

    // Next-state: a flush wins over everything. A pop shifts slot 1 into slot 0.
    // A push lands in the first free slot after any shift.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        cnt_d    = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else if (do_pop && push) begin
            if (cnt_q == 2'd1) begin
                mem_d[0] = push_data;
            end else begin
                mem_d[0] = mem_q[1];
                mem_d[1] = push_data;
            end
        end else if (do_pop) begin
            mem_d[0] = mem_q[1];
            cnt_d    = cnt_q - 2'd1;
        end else if (push && (cnt_q != 2'd2)) begin
            if (cnt_q == 2'd0) begin
                mem_d[0] = push_data;
            end else begin
                mem_d[1] = push_data;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Storage and count registers. Reset clears the storage as well as the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[0];
    assign count = cnt_q;

endmodule

// File: rtl/ifetch.sv
// ifetch: PC generation, redirect handling and the fetch buffer feeding decode.
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to enable the misaligned-fetch
// trap. A push from a misaligned PC enqueues a flagged NOP and stops fetching
// until a redirect or reset arrives. Without the macro, redirect targets are
// forced to word alignment and out_misaligned stays at 0.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_misaligned
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            push, pop;
    fetch_entry_t    push_data;
    fetch_entry_t    head;
    logic [1:0]      count;
    logic            halted;

`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam logic MISALIGN_EN = 1'b1;
    logic halt_q, halt_d;
    assign halted = halt_q;
`else
    localparam logic MISALIGN_EN = 1'b0;
    assign halted = 1'b0;
`endif

    assign pop  = out_valid && out_ready;
    assign push = !redirect_valid && !halted && ((count != 2'd2) || pop);

    // Builds the entry to enqueue. A misaligned PC is replaced by a flagged NOP
    // only when the trap is enabled.
    always_comb begin
        push_data.pc         = pc_q;
        push_data.inst       = imem_rdata;
        push_data.misaligned = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (pc_q[1:0] != 2'b00) begin
            push_data.inst       = NOP_INST;
            push_data.misaligned = 1'b1;
        end
`endif
    end

    // PC and halt next-state. A redirect has priority over a sequential advance.
    // The increment wraps naturally at 2^XLEN.
    always_comb begin
        pc_d = pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
        halt_d = halt_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            halt_d = 1'b0;
        end else if (push) begin
            pc_d = pc_q + PC_INC;
            if (push_data.misaligned) halt_d = 1'b1;
        end
`else
        if (redirect_valid) begin
            pc_d = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
        end else if (push) begin
            pc_d = pc_q + PC_INC;
        end
`endif
    end

    // PC and halt registers. Reset takes priority over redirect and push.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
            halt_q <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            halt_q <= halt_d;
`endif
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign imem_addr      = pc_q;
    assign out_valid      = (count != 2'd0);
    assign out_pc         = head.pc;
    assign out_inst       = head.inst;
    // Gated so that the flag reads constant 0 when the trap is compiled out.
    assign out_misaligned = MISALIGN_EN & head.misaligned;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch. The main instance uses RESET_PC=0. A second instance
// with RESET_PC=0xFFFFFFFC shares the clock and reset and covers PC wrap-around.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata;
    logic        out_valid, out_ready, out_misaligned;
    logic [31:0] out_pc, out_inst;

    logic [31:0] w_imem_addr, w_imem_rdata, w_out_pc, w_out_inst;
    logic        w_out_valid, w_out_misaligned;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: word at byte address A is 0x10000000 + A/4.
    assign imem_rdata   = 32'h1000_0000 + (imem_addr >> 2);
    assign w_imem_rdata = 32'h1000_0000 + (w_imem_addr >> 2);

    ifetch #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_misaligned(out_misaligned)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata), .out_valid(w_out_valid),
        .out_ready(1'b1), .out_pc(w_out_pc), .out_inst(w_out_inst),
        .out_misaligned(w_out_misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst, input logic mis);
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".inst"}, out_inst, inst);
        chk({tag, ".mis"}, {31'b0, out_misaligned}, {31'b0, mis});
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        step(); step();
        // Held in reset.
        chk_head("rst", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.waddr", w_imem_addr, 32'hFFFF_FFFC);
        reset = 1'b0;
        // Just after release, before the first edge without reset.
        chk_head("post_rst", 1'b0, 32'h0, 32'h0, 1'b0);

        // Streaming with out_ready=1.
        step();
        chk_head("s0", 1'b1, 32'h0, 32'h1000_0000, 1'b0);
        chk("s0.addr", imem_addr, 32'h4);
        chk("w0.pc", w_out_pc, 32'hFFFF_FFFC);
        chk("w0.inst", w_out_inst, 32'h4FFF_FFFF);
        chk("w0.addr", w_imem_addr, 32'h0);
        step();
        chk_head("s1", 1'b1, 32'h4, 32'h1000_0001, 1'b0);
        chk("w1.pc", w_out_pc, 32'h0);
        chk("w1.inst", w_out_inst, 32'h1000_0000);
        step();
        chk_head("s2", 1'b1, 32'h8, 32'h1000_0002, 1'b0);

        // Stall: out_ready=0 for four cycles from the first valid entry.
        reset = 1'b1; step(); reset = 1'b0; out_ready = 1'b0;
        step();
        chk_head("st0", 1'b1, 32'h0, 32'h1000_0000, 1'b0);
        chk("st0.addr", imem_addr, 32'h4);
        step();
        chk("st1.addr", imem_addr, 32'h8);
        step();
        chk_head("st2", 1'b1, 32'h0, 32'h1000_0000, 1'b0);
        chk("st2.addr", imem_addr, 32'h8);
        step();
        chk_head("st3", 1'b1, 32'h0, 32'h1000_0000, 1'b0);
        chk("st3.addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        step();
        chk_head("dr1", 1'b1, 32'h4, 32'h1000_0001, 1'b0);
        step();
        chk_head("dr2", 1'b1, 32'h8, 32'h1000_0002, 1'b0);
        step();
        chk_head("dr3", 1'b1, 32'hC, 32'h1000_0003, 1'b0);

        // Redirect while full.
        out_ready = 1'b0;
        step();
        chk("full.addr", imem_addr, 32'h14);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("rd.valid", {31'b0, out_valid}, 32'h0);
        chk("rd.addr", imem_addr, 32'h100);
        step();
        chk_head("rd0", 1'b1, 32'h100, 32'h1000_0040, 1'b0);
        out_ready = 1'b1;
        step();
        chk_head("rd1", 1'b1, 32'h104, 32'h1000_0041, 1'b0);

        // Misaligned redirect target.
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        chk("ma.valid", {31'b0, out_valid}, 32'h0);
        step();
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk_head("ma0", 1'b1, 32'h102, 32'h0000_0013, 1'b1);
        step();
        chk("ma1.valid", {31'b0, out_valid}, 32'h0);
        step();
        chk("ma2.valid", {31'b0, out_valid}, 32'h0);
`else
        chk_head("ma0", 1'b1, 32'h100, 32'h1000_0040, 1'b0);
        step();
        chk_head("ma1", 1'b1, 32'h104, 32'h1000_0041, 1'b0);
        step();
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        step();
        chk_head("rs0", 1'b1, 32'h200, 32'h1000_0080, 1'b0);

        // Reset coinciding with a redirect.
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1;
        step();
        reset = 1'b0; redirect_valid = 1'b0;
        chk_head("rr", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rr.addr", imem_addr, 32'h0);
        step();
        chk_head("rr1", 1'b1, 32'h0, 32'h1000_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 0: PC loaded on reset; must be 4-byte aligned.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port redirect_valid  input  1  redirect request from execute (branch/jump taken).
REQ-005 Port redirect_pc  input  XLEN  redirect target; sampled when redirect_valid=1.
REQ-006 Port imem_addr  output  XLEN  byte address to instruction memory; combinational copy of PC register.
REQ-007 Port imem_rdata  input  XLEN  instruction word returned combinationally by instruction memory for imem_addr.
REQ-008 Port out_valid  output  1  head entry holds a valid fetched instruction.
REQ-009 Port out_ready  input  1  decode accepts head entry this cycle.
REQ-010 Port out_pc  output  XLEN  PC of head entry.
REQ-011 Port out_inst  output  XLEN  instruction word of head entry.
REQ-012 Port out_misaligned  output  1  head entry carries a misaligned-fetch exception.

Function
REQ-013 Buffering: 2-entry FIFO of {pc, inst, misaligned}; out_* driven from head; out_valid = (count != 0).
REQ-014 Pop: head removed when out_valid && out_ready.
REQ-015 Push: when no redirect, not halted, and (count < 2 or pop this cycle): enqueue {PC, imem_rdata, 0}; PC <= PC + 4.
REQ-016 Simultaneous push and pop at count=2 or count=1: count unchanged; order preserved; no entry lost or duplicated.
REQ-017 Full with no pop: no push; PC and FIFO contents held unchanged.
REQ-018 PC increment wraps modulo 2^XLEN (0xFFFFFFFC + 4 = 0x00000000 for XLEN=32).
REQ-019 Redirect (highest priority): FIFO flushed (count <= 0), PC <= redirect_pc, no push that cycle, halt cleared; a pop in the same cycle is honoured at the port but has no further effect.
REQ-020 Latency: instruction at PC P shows out_valid=1 with out_pc=P one cycle after P is on imem_addr; after a redirect, out_valid=0 for exactly one cycle, then out_pc=redirect_pc.
REQ-021 Steady state with out_ready held 1: one instruction delivered per cycle, no bubbles.
REQ-022 out_pc, out_inst and out_misaligned remain stable while out_valid=1 and out_ready=0.

Reset
REQ-023 On reset=1 at a clock edge: PC <= RESET_PC, count <= 0, halt <= 0, all FIFO storage <= 0.
REQ-024 Outputs during and immediately after reset: out_valid=0, out_pc=0, out_inst=0, out_misaligned=0, imem_addr=RESET_PC.
REQ-025 Reset asserted mid-stream overrides push, pop and redirect in the same cycle.

Configuration
REQ-026 Macro IFETCH_MISALIGN_TRAP_EN defined: if PC[1:0] != 0 at push time, enqueue {PC, 0x00000013 (NOP), 1}, set halt, and suppress further pushes until redirect or reset.
REQ-027 Macro undefined: redirect_pc[1:0] forced to 0 when loaded; out_misaligned tied 0; no halt state exists.

Structure
REQ-028 XLEN, the NOP encoding 0x00000013 and the PC increment constant 4 come from the shared constants header; the FIFO entry record type is defined there.
REQ-029 The FIFO is one sub-module, fetch_fifo (depth 2, push/pop/flush, count output); PC/redirect/halt control stays in ifetch.

Verification
REQ-030 Reset with RESET_PC=0, out_ready=1 -> out_valid rises one cycle after reset release; out_pc sequence 0x0, 0x4, 0x8; out_inst equals memory words 0, 1, 2.
REQ-031 out_ready=0 for 4 cycles after the first valid -> count saturates at 2, imem_addr holds 0x8, outputs stable; out_ready=1 -> 0x0, 0x4, 0x8 delivered with no gaps.
REQ-032 Redirect to 0x100 while FIFO full -> next cycle out_valid=0; following cycle out_pc=0x100, then 0x104.
REQ-033 RESET_PC=0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000.
REQ-034 Macro defined, redirect to 0x102 -> one entry with out_pc=0x102, out_inst=0x00000013, out_misaligned=1, then out_valid=0 until redirect to 0x200 resumes at 0x200; macro undefined -> same stimulus yields out_pc=0x100, out_misaligned=0.
REQ-035 reset asserted together with redirect_valid=1 (redirect_pc=0x300) and out_ready=1 -> next cycle PC=RESET_PC, out_valid=0.
